// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
//
// Request/response front-end placed directly upstream of a mem_core. It turns
// a valid/ready request channel into single-cycle mem_core accesses and
// registers the core's combinational read data into a valid/ready response
// channel. After reset it can optionally sweep every location to InitValue
// before the first request is accepted.
//
// Parameters
//   ElemWidth    data element width, must match the attached mem_core
//   AddrWidth    address width, Depth = 2**AddrWidth
//   ClearOnReset 1: run the clearing sweep after reset, 0: go straight to RUN
//   InitValue    value written to every location during the sweep
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_ni       synchronous active-low reset
//   req_valid_i  request valid
//   req_ready_o  request ready
//   req_we_i     1 = write, 0 = read
//   req_addr_i   request address
//   req_wdata_i  request write data
//   rsp_valid_o  read response valid
//   rsp_ready_i  read response ready
//   rsp_rdata_o  read response data
//   mem_we_o     to mem_core we_i
//   mem_addr_o   to mem_core addr_i
//   mem_wdata_o  to mem_core wdata_i
//   mem_rdata_i  from mem_core rdata_o (combinational)
//   init_done_o  high once the clearing sweep has finished (always high in RUN)
// ---------------------------------------------------------------------------
module mem_req_ctrl #(
    parameter int                   ElemWidth    = 8,
    parameter int                   AddrWidth    = 8,
    parameter bit                   ClearOnReset = 1'b1,
    parameter logic [ElemWidth-1:0] InitValue    = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [ElemWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ElemWidth-1:0] rsp_rdata_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [ElemWidth-1:0] mem_wdata_o,
    input  logic [ElemWidth-1:0] mem_rdata_i,
    output logic                 init_done_o
);

    localparam int Depth = 2 ** AddrWidth;

    // The sweep counter carries one extra bit so the last address compares
    // unambiguously against Depth-1 without relying on wrap-around.
    localparam logic [AddrWidth:0] CntLast = (AddrWidth + 1)'(Depth - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic   [AddrWidth:0]   cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic   [ElemWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                   accept;

    // State, sweep counter and response register. Reset clears all of them,
    // so a reset in the middle of the sweep or with a response outstanding
    // leaves nothing behind.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ClearOnReset ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        req_ready_o = 1'b0;
        init_done_o = 1'b0;
        accept      = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = req_addr_i;
        mem_wdata_o = req_wdata_i;

        unique case (state_q)
            ST_INIT: begin
                // One location per cycle; the request channel stays closed
                // until the last location has been written.
                mem_we_o    = 1'b1;
                mem_addr_o  = cnt_q[AddrWidth-1:0];
                mem_wdata_o = InitValue;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                init_done_o = 1'b1;
                // Ready depends only on the response slot: it is free, or it
                // drains this very cycle. This gives one read per cycle while
                // the consumer keeps rsp_ready_i high.
                req_ready_o = !rsp_valid_q || rsp_ready_i;
                accept      = req_valid_i && req_ready_o;
                mem_we_o    = accept && req_we_i;

                // A newly accepted read refills the slot even if the old
                // response leaves this cycle; otherwise a completed handshake
                // empties it. A stalled response keeps its data untouched.
                if (accept && !req_we_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_rdata_i;
                end else if (rsp_valid_q && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_req_ctrl
//
// Drives mem_req_ctrl (ElemWidth=8, AddrWidth=4) attached to a small
// behavioural mem_core model. Stimulus pushes the expected memory writes and
// read responses into queues; an independent monitor pops and compares them
// whenever the DUT writes memory or completes a response handshake.
// ---------------------------------------------------------------------------
module tb_mem_req_ctrl;

    localparam int ElemWidth = 8;
    localparam int AddrWidth = 4;
    localparam int Depth     = 16;

    logic                 clk;
    logic                 rstN;
    logic                 reqValid;
    logic                 reqReady;
    logic                 reqWe;
    logic [AddrWidth-1:0] reqAddr;
    logic [ElemWidth-1:0] reqWdata;
    logic                 rspValid;
    logic                 rspReady;
    logic [ElemWidth-1:0] rspRdata;
    logic                 memWe;
    logic [AddrWidth-1:0] memAddr;
    logic [ElemWidth-1:0] memWdata;
    logic [ElemWidth-1:0] memRdata;
    logic                 initDone;

    int nChecks = 0;
    int nFails  = 0;
    int rspCount = 0;

    logic [11:0]          writeQ[$];
    logic [ElemWidth-1:0] rspQ[$];
    logic [ElemWidth-1:0] refMem [Depth];
    logic [ElemWidth-1:0] memArray [Depth];

    mem_req_ctrl #(
        .ElemWidth   (ElemWidth),
        .AddrWidth   (AddrWidth),
        .ClearOnReset(1'b1),
        .InitValue   (8'h00)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .req_valid_i(reqValid),
        .req_ready_o(reqReady),
        .req_we_i   (reqWe),
        .req_addr_i (reqAddr),
        .req_wdata_i(reqWdata),
        .rsp_valid_o(rspValid),
        .rsp_ready_i(rspReady),
        .rsp_rdata_o(rspRdata),
        .mem_we_o   (memWe),
        .mem_addr_o (memAddr),
        .mem_wdata_o(memWdata),
        .mem_rdata_i(memRdata),
        .init_done_o(initDone)
    );

    // Behavioural mem_core: synchronous write, combinational read.
    always_ff @(posedge clk) begin
        if (memWe) begin
            memArray[memAddr] <= memWdata;
        end
    end
    assign memRdata = memArray[memAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Monitor: sampled mid-cycle, after stimulus has registered expectations.
    always begin
        @(negedge clk);
        #2;
        if (rstN === 1'b1) begin
            if (memWe === 1'b1) begin
                if (writeQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'({memAddr, memWdata}), 32'hFFFF);
                end else begin
                    checkOutput("mem_write", 32'({memAddr, memWdata}), 32'(writeQ.pop_front()));
                end
            end
            if (rspValid === 1'b1 && rspReady === 1'b1) begin
                rspCount++;
                if (rspQ.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'(rspRdata), 32'hFFFF);
                end else begin
                    checkOutput("rsp_rdata", 32'(rspRdata), 32'(rspQ.pop_front()));
                end
            end
        end
    end

    // Issues one request and holds it until accepted; expectations are
    // pushed at the sample point where the acceptance is decided.
    task automatic applyStimulus(input logic we, input logic [AddrWidth-1:0] addr,
                                 input logic [ElemWidth-1:0] data, output int waited);
        reqValid = 1'b1;
        reqWe    = we;
        reqAddr  = addr;
        reqWdata = data;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (reqReady === 1'b1) break;
            waited++;
            if (waited > 50) begin
                checkOutput("accept_timeout", 32'(0), 32'(1));
                break;
            end
            @(posedge clk);
            #1;
        end
        if (waited <= 50) begin
            if (we) begin
                writeQ.push_back({addr, data});
                refMem[addr] = data;
            end else begin
                rspQ.push_back(refMem[addr]);
            end
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic resetDut();
        rstN     = 1'b0;
        reqValid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rspValid), 32'(0));
        checkOutput("reset_rsp_rdata", 32'(rspRdata), 32'(0));
        checkOutput("reset_req_ready", 32'(reqReady), 32'(0));
        checkOutput("reset_init_done", 32'(initDone), 32'(0));
        @(posedge clk);
        #1;
        writeQ.delete();
        rspQ.delete();
        rspReady = 1'b1;
    endtask

    // Releases reset and watches n sweep cycles while a write request is held
    // pending; n < Depth re-asserts reset in the middle of the sweep.
    task automatic initSweep(input int n);
        for (int c = 0; c < n; c++) begin
            writeQ.push_back({4'(c), 8'h00});
        end
        if (n == Depth) begin
            for (int i = 0; i < Depth; i++) refMem[i] = 8'h00;
        end
        rstN     = 1'b1;
        reqValid = 1'b1;
        reqWe    = 1'b1;
        reqAddr  = 4'd9;
        reqWdata = 8'h77;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checkOutput("init_done_low", 32'(initDone), 32'(0));
            checkOutput("init_req_ready", 32'(reqReady), 32'(0));
            checkOutput("init_mem_we", 32'(memWe), 32'(1));
            @(posedge clk);
            #1;
        end
        reqValid = 1'b0;
        if (n == Depth) begin
            @(negedge clk);
            checkOutput("init_done_high", 32'(initDone), 32'(1));
            @(posedge clk);
            #1;
        end else begin
            rstN = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int startCount;
        rstN     = 1'b0;
        reqValid = 1'b0;
        reqWe    = 1'b0;
        reqAddr  = '0;
        reqWdata = '0;
        rspReady = 1'b1;

        $display("[TB] Reset and full clearing sweep");
        resetDut();
        initSweep(Depth);

        $display("[TB] Write then read of the same address");
        applyStimulus(1'b1, 4'd3, 8'hA5, waited);
        applyStimulus(1'b0, 4'd3, 8'h00, waited);
        checkOutput("raw_rsp_valid", 32'(rspValid), 32'(1));
        checkOutput("raw_rsp_rdata", 32'(rspRdata), 32'hA5);
        @(posedge clk);
        #1;

        $display("[TB] Response back-pressure");
        rspReady = 1'b0;
        applyStimulus(1'b0, 4'd3, 8'h00, waited);
        reqValid = 1'b1;
        reqWe    = 1'b0;
        reqAddr  = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_req_ready", 32'(reqReady), 32'(0));
            checkOutput("hold_rsp_valid", 32'(rspValid), 32'(1));
            checkOutput("hold_rsp_rdata", 32'(rspRdata), 32'hA5);
            checkOutput("hold_no_write", 32'(memWe), 32'(0));
        end
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        applyStimulus(1'b0, 4'd5, 8'h00, waited);
        checkOutput("release_accept_wait", 32'(waited), 32'(0));
        checkOutput("release_rsp_rdata", 32'(rspRdata), 32'h00);

        $display("[TB] Fill memory, then back-to-back reads");
        for (int i = 0; i < Depth; i++) begin
            applyStimulus(1'b1, 4'(i), 8'(i * 17) ^ 8'h5A, waited);
        end
        @(posedge clk);
        #1;
        startCount = rspCount;
        for (int i = 0; i < Depth; i++) begin
            applyStimulus(1'b0, 4'(i), 8'h00, waited);
            checkOutput("b2b_accept_wait", 32'(waited), 32'(0));
            checkOutput("b2b_rsp_valid", 32'(rspValid), 32'(1));
        end
        @(negedge clk);
        #3;
        checkOutput("b2b_rsp_count", 32'(rspCount - startCount), 32'(Depth));
        @(posedge clk);
        #1;

        $display("[TB] Reset in the middle of the sweep");
        resetDut();
        initSweep(7);
        resetDut();
        initSweep(Depth);
        applyStimulus(1'b0, 4'd2, 8'h00, waited);
        checkOutput("after_midinit_rdata", 32'(rspRdata), 32'h00);
        @(posedge clk);
        #1;

        $display("[TB] Reset with a response pending");
        applyStimulus(1'b1, 4'd9, 8'h3C, waited);
        rspReady = 1'b0;
        applyStimulus(1'b0, 4'd9, 8'h00, waited);
        checkOutput("pending_rsp_valid", 32'(rspValid), 32'(1));
        checkOutput("pending_rsp_rdata", 32'(rspRdata), 32'h3C);
        resetDut();
        initSweep(Depth);
        applyStimulus(1'b0, 4'd9, 8'h00, waited);
        checkOutput("after_reset_rdata", 32'(rspRdata), 32'h00);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("write_queue_empty", 32'(writeQ.size()), 32'(0));
        checkOutput("rsp_queue_empty", 32'(rspQ.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
